mul_seq: RTL and testbench
==========================

# mul_seq

Sequential shift-add multiplier for the ALU datapath: accepts two WIDTH-bit operands on a start pulse and produces a 2*WIDTH-bit product after WIDTH iterations, using one WIDTH-bit add per cycle. It sits beside the 32-bit adder stage and drives the ALU result mux for multiply opcodes. A start/busy/done handshake lets the control FSM stall while it runs.

## Interface
- WIDTH, 32, operand width in bits; supported values are 8 to 64, even.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- sgn  in  1  signed mode; present only with MUL_SIGNED_EN; sampled with start.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; p is valid while it is high.
- p  out  2*WIDTH  product; holds its value until the next accepted start.

## Operation
- One clock, clk. Reset is asynchronous and active-high on rst. On reset: state=IDLE, busy=0, done=0, p=0, count=0, internal registers=0.
- States:
  - IDLE: start=1 at an edge captures the operands, loads hi=0, lo=b, mcand=a, count=0, and moves to RUN.
  - RUN: one iteration per edge. After WIDTH iterations, move to DONE.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- Iteration step:
  - If lo[0]=1, then {c,sum}=hi+mcand (a WIDTH+1-bit add). Otherwise {c,sum}={0,hi}.
  - Update {hi,lo} <= {c,sum,lo[WIDTH-1:1]}.
- On the RUN->DONE edge, p <= {hi,lo} after the final iteration. Arithmetic is unsigned and modulo-free; the full 2*WIDTH-bit result is exact.
- count is $clog2(WIDTH)+1 bits wide. The last iteration happens when count==WIDTH-1. count never wraps.
- start is ignored in RUN and DONE: no queuing and no error.
- Operands change freely after acceptance; only the captured copies are used.
- rst asserted mid-RUN or in DONE aborts immediately. The done pulse is lost and p=0.

## Timing
- Start accepted at edge N: busy=1 from edge N. The RUN iterations occur at edges N+1..N+WIDTH. done=1 and p is valid in the cycle after edge N+WIDTH. busy=0 after edge N+WIDTH+1.
- Start-to-done latency is WIDTH+1 cycles; issue interval is WIDTH+2 cycles.
- A start asserted in the cycle after done (IDLE) is accepted normally. There is no combinational path from start to busy or done.

## Configuration
- MUL_SIGNED_EN defined:
  - The sgn port exists.
  - With sgn=1 at acceptance, a and b are treated as two's complement. Their magnitudes are loaded into mcand and lo, and the sign XOR is registered.
  - On the RUN->DONE edge, p is negated (two's complement, 2*WIDTH bits) if the registered sign is 1.
  - The most-negative operand is handled exactly: its magnitude is 2^(WIDTH-1).
  - Latency is unchanged.
- MUL_SIGNED_EN undefined: no sgn port; unsigned operation only; no negation logic.

## Structure
- Package mul_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default-width constant MUL_WIDTH=32;
  - a function giving the count width for a given WIDTH.
- One sub-module, mul_step: combinational single iteration. It takes hi, lo and mcand and returns the next hi and lo, and contains the WIDTH+1-bit add.
- mul_seq holds the FSM, the counter, the operand and sign registers, and the output register.

## Test plan
- 3 x 5 (WIDTH=32), start at edge N -> done pulse in the cycle after edge N+32; p=0x000000000000000F; busy=1 through done and 0 the next cycle.
- 0xFFFFFFFF x 0xFFFFFFFF -> p=0xFFFFFFFE00000001. 0 x 0x12345678 -> p=0.
- start held high for 40 cycles with operands changing each cycle -> only the first operands are used; a second operation is accepted in the IDLE cycle following done.
- rst pulse 10 cycles into RUN -> busy=0, done=0 and p=0 at once; a subsequent 7 x 9 gives p=63 with full latency.
- With MUL_SIGNED_EN and sgn=1:
  - -3 x 5 -> p=0xFFFFFFFFFFFFFFF1;
  - 0x80000000 x 0x80000000 -> p=0x4000000000000000;
  - sgn=0 with the same operands gives the unsigned product.

Source files
------------

// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the sequential shift-add multiplier (mul_seq).
//   - state_t     : FSM state encoding (IDLE, RUN, DONE)
//   - MUL_WIDTH   : default operand width
//   - count_width : iteration-counter width for a given operand width
// Optional feature macro used by the files that import this package:
//   MUL_SIGNED_EN : adds the sgn port and two's-complement operation.
// -----------------------------------------------------------------------------
package mul_pkg;

   localparam int MUL_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // One extra bit over log2 so the counter can represent WIDTH itself
   // without aliasing, even though it stops at WIDTH-1.
   function automatic int count_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/mul_if.sv
// -----------------------------------------------------------------------------
// mul_if
// Request/response bundle between the ALU control FSM (master) and the
// multiplier (slave).
//   start : request pulse/level, sampled only while the multiplier is idle
//   a, b  : WIDTH-bit multiplicand / multiplier, sampled with start
//   sgn   : signed mode, sampled with start (only with MUL_SIGNED_EN)
//   busy  : multiplier is not idle
//   done  : one-cycle pulse, p is valid while it is high
//   p     : 2*WIDTH-bit product, held until the next completed operation
// Macro: MUL_SIGNED_EN adds the sgn signal.
// -----------------------------------------------------------------------------
interface mul_if
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
);

   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
`ifdef MUL_SIGNED_EN
   logic                 sgn;
`endif
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   p;

`ifdef MUL_SIGNED_EN
   modport master (
      output start, a, b, sgn,
      input  busy, done, p
   );

   modport slave (
      input  start, a, b, sgn,
      output busy, done, p
   );
`else
   modport master (
      output start, a, b,
      input  busy, done, p
   );

   modport slave (
      input  start, a, b,
      output busy, done, p
   );
`endif

endinterface

// File: rtl/mul_step.sv
// -----------------------------------------------------------------------------
// mul_step
// One combinational shift-add iteration of the multiplier.
//   i_hi    : upper half of the partial product
//   i_lo    : lower half; its LSB is the multiplier bit being consumed
//   i_mcand : multiplicand (magnitude)
//   o_hi    : next upper half
//   o_lo    : next lower half
// The WIDTH+1-bit add keeps the carry, so {o_hi, o_lo} is the exact
// partial product shifted right by one.
// -----------------------------------------------------------------------------
module mul_step
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_mcand,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic [WIDTH:0] w_sum;   // {carry, sum}

   // NOTE: every signal written in always_comb gets a value before any
   // condition; a path that leaves it unassigned would infer a latch.
   always_comb begin
      w_sum = {1'b0, i_hi};
      if (i_lo[0]) begin
         w_sum = {1'b0, i_hi} + {1'b0, i_mcand};
      end
   end

   // Shift {carry, sum, lo} right by one: the carry enters hi, the sum LSB
   // becomes a settled product bit at the top of lo.
   assign o_hi = w_sum[WIDTH:1];
   assign o_lo = {w_sum[0], i_lo[WIDTH-1:1]};

endmodule

// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq
// Sequential shift-add multiplier: WIDTH iterations of one WIDTH-bit add each.
// Start-to-done latency is WIDTH+1 cycles, issue interval WIDTH+2 cycles.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset (aborts any operation, clears p)
//   bus : mul_if slave modport (start, a, b, [sgn], busy, done, p)
// Macro: MUL_SIGNED_EN enables two's-complement operation selected by sgn.
//   Operand magnitudes are multiplied and the result negated at the end when
//   the operand signs differ; latency is unchanged.
// -----------------------------------------------------------------------------
module mul_seq
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic  clk,
   input  logic  rst,
   mul_if.slave  bus
);

   localparam int             CW   = count_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   state_t               r_state;
   state_t               w_state_nxt;
   logic [CW-1:0]        r_count;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic [WIDTH-1:0]     r_mcand;
   logic [2*WIDTH-1:0]   r_p;

   logic [WIDTH-1:0]     w_hi_nxt;
   logic [WIDTH-1:0]     w_lo_nxt;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic [2*WIDTH-1:0]   w_prod;
   logic                 w_last;

   assign w_last = (r_count == LAST);

   // ------------------------------------------------------------------------
   // Operand conditioning and final result
   // ------------------------------------------------------------------------
`ifdef MUL_SIGNED_EN
   logic                 r_neg;
   logic                 w_a_neg;
   logic                 w_b_neg;
   logic                 w_neg;

   assign w_a_neg = bus.sgn & bus.a[WIDTH-1];
   assign w_b_neg = bus.sgn & bus.b[WIDTH-1];
   assign w_neg   = w_a_neg ^ w_b_neg;

   // The most-negative value negates to itself, which read as unsigned is
   // exactly its magnitude 2^(WIDTH-1), so no extra bit is needed.
   assign w_a_mag = w_a_neg ? (~bus.a + 1'b1) : bus.a;
   assign w_b_mag = w_b_neg ? (~bus.b + 1'b1) : bus.b;

   // Negate the full 2*WIDTH-bit result of the final iteration.
   assign w_prod  = r_neg ? (~{w_hi_nxt, w_lo_nxt} + 1'b1)
                          : {w_hi_nxt, w_lo_nxt};
`else
   assign w_a_mag = bus.a;
   assign w_b_mag = bus.b;
   assign w_prod  = {w_hi_nxt, w_lo_nxt};
`endif

   // ------------------------------------------------------------------------
   // Single iteration
   // ------------------------------------------------------------------------
   mul_step #(
      .WIDTH   (WIDTH)
   ) u_step (
      .i_hi    (r_hi),
      .i_lo    (r_lo),
      .i_mcand (r_mcand),
      .o_hi    (w_hi_nxt),
      .o_lo    (w_lo_nxt)
   );

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath: operand capture, iteration, result register
   // ------------------------------------------------------------------------
   // NOTE: the datapath registers are reset along with the FSM because an
   // abort must leave p (and all internal state) at zero, not stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_mcand <= '0;
         r_p     <= '0;
`ifdef MUL_SIGNED_EN
         r_neg   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_count <= '0;
                  r_hi    <= '0;
                  r_lo    <= w_b_mag;
                  r_mcand <= w_a_mag;
`ifdef MUL_SIGNED_EN
                  r_neg   <= w_neg;
`endif
               end
            end
            RUN: begin
               r_hi <= w_hi_nxt;
               r_lo <= w_lo_nxt;
               if (w_last) begin
                  // Final iteration: publish the product; the counter
                  // stays at WIDTH-1 rather than wrapping.
                  r_p <= w_prod;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            default: begin
               // DONE: hold everything; start is ignored here.
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: all decoded from registered state, never from start.
   // ------------------------------------------------------------------------
   assign bus.busy = (r_state != IDLE);
   assign bus.done = (r_state == DONE);
   assign bus.p    = r_p;

endmodule

// File: tb/tb_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_seq
// Directed self-checking bench for mul_seq (WIDTH = MUL_WIDTH = 32).
// Expected products are pushed to a scoreboard queue when an operation is
// issued and popped when the done pulse is observed. Inputs are driven and
// outputs sampled on the falling clock edge.
// Macro: MUL_SIGNED_EN enables the signed-mode steps.
// -----------------------------------------------------------------------------
module tb_mul_seq;
   import mul_pkg::*;

   localparam int W  = MUL_WIDTH;
   localparam int PW = 2 * W;

   logic clk = 1'b0;
   logic rst;

   mul_if #(.WIDTH(W)) bus ();

   mul_seq #(
      .WIDTH (W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int              checks = 0;
   int              errors = 0;
   logic [PW-1:0]   sb_q[$];

   // -------------------------------------------------------------------------
   task automatic check(input string tag, input logic [PW-1:0] obs,
                        input logic [PW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference product computed with the simulator's own multiply.
   function automatic logic [PW-1:0] model_u(input logic [W-1:0] a_v,
                                             input logic [W-1:0] b_v);
      logic [PW-1:0] ea;
      logic [PW-1:0] eb;
      ea = {{W{1'b0}}, a_v};
      eb = {{W{1'b0}}, b_v};
      return ea * eb;
   endfunction

   // Drive one start in IDLE; optionally record the expected product.
   // Returns at the falling edge right after the accepting edge.
   task automatic start_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                           input logic s_v, input bit push,
                           input logic [PW-1:0] exp);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = a_v;
      bus.b     = b_v;
`ifdef MUL_SIGNED_EN
      bus.sgn   = s_v;
`else
      if (s_v) $display("note: sgn request ignored in unsigned build");
`endif
      if (push) sb_q.push_back(exp);
      #1;
      check("busy_not_comb_from_start", PW'(bus.busy), PW'(0));
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = ~a_v;   // scramble: only the captured copies may matter
      bus.b     = ~b_v;
      check("busy_after_accept", PW'(bus.busy), PW'(1));
   endtask

   // Wait (bounded) for done, compare against the scoreboard head, then
   // check the cycle after done. Called at the falling edge after accept
   // when chk_lat is set, so done should appear at cycle W+1.
   task automatic wait_done(input string tag, input bit chk_lat);
      int             k;
      logic [PW-1:0]  exp;
      k = 1;
      while (!bus.done && k < W + 8) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_done_seen"}, PW'(bus.done), PW'(1));
      if (bus.done) begin
         if (chk_lat) check({tag, "_latency"}, PW'(k), PW'(W + 1));
         check({tag, "_busy_in_done"}, PW'(bus.busy), PW'(1));
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
            exp = '0;
         end else begin
            exp = sb_q.pop_front();
            check({tag, "_p"}, bus.p, exp);
         end
         @(negedge clk);
         check({tag, "_busy_after_done"}, PW'(bus.busy), PW'(0));
         check({tag, "_done_one_cycle"}, PW'(bus.done), PW'(0));
         check({tag, "_p_held"}, bus.p, exp);
      end
   endtask

   // -------------------------------------------------------------------------
   // Watchdog
   // -------------------------------------------------------------------------
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected summary before 200000");
      $fatal(1, "watchdog expired");
   end

   // -------------------------------------------------------------------------
   // Directed sequence
   // -------------------------------------------------------------------------
   initial begin
      bit            first_seen;
      bit            second_pushed;
      int            done_cyc;
      logic [W-1:0]  na;
      logic [W-1:0]  nb;

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
`ifdef MUL_SIGNED_EN
      bus.sgn   = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("reset_busy", PW'(bus.busy), PW'(0));
      check("reset_done", PW'(bus.done), PW'(0));
      check("reset_p",    bus.p,         PW'(0));
      rst = 1'b0;

      // Basic products.
      start_op(32'd3, 32'd5, 1'b0, 1'b1, 64'h0000_0000_0000_000F);
      wait_done("mul_3x5", 1'b1);
      start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFE_0000_0001);
      wait_done("mul_max", 1'b1);
      start_op(32'h0, 32'h1234_5678, 1'b0, 1'b1, 64'h0);
      wait_done("mul_zero", 1'b1);
      start_op(32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1, 64'h0000_0004_FFFF_FFF1);
      wait_done("mul_unsigned_m3x5", 1'b1);

      // start held high for 40 cycles, operands changing every cycle.
      first_seen    = 1'b0;
      second_pushed = 1'b0;
      done_cyc      = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 32'd11;
      bus.b     = 32'd13;
      sb_q.push_back(64'd143);
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (bus.done && !first_seen) begin
            first_seen = 1'b1;
            done_cyc   = cyc;
            check("stress_first_p", bus.p, sb_q.pop_front());
         end
         na = W'($urandom);
         nb = W'($urandom);
         if (!bus.busy && first_seen && !second_pushed) begin
            // IDLE cycle after done: these operands get accepted.
            second_pushed = 1'b1;
            sb_q.push_back(model_u(na, nb));
         end
         bus.a = na;
         bus.b = nb;
      end
      bus.start = 1'b0;
      check("stress_first_latency", PW'(done_cyc), PW'(W + 1));
      check("stress_second_accepted", PW'(second_pushed), PW'(1));
      wait_done("stress_second", 1'b0);

      // Abort mid-RUN with reset.
      start_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b0, 64'h0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", PW'(bus.busy), PW'(0));
      check("abort_done", PW'(bus.done), PW'(0));
      check("abort_p",    bus.p,         PW'(0));
      @(negedge clk);
      rst = 1'b0;
      start_op(32'd7, 32'd9, 1'b0, 1'b1, 64'd63);
      wait_done("after_abort_7x9", 1'b1);

`ifdef MUL_SIGNED_EN
      start_op(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
      wait_done("signed_m3x5", 1'b1);
      start_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000);
      wait_done("signed_minmin", 1'b1);
      start_op(32'h8000_0000, 32'd3, 1'b1, 1'b1, 64'hFFFF_FFFE_8000_0000);
      wait_done("signed_minx3", 1'b1);
      start_op(32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1, 64'h0000_0004_FFFF_FFF1);
      wait_done("sgn0_m3x5", 1'b1);
`endif

      check("scoreboard_drained", PW'(sb_q.size()), PW'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
